// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants, initial hash value and FSM encoding.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

// File: rtl/sha256_round_16_2.sv
// sha256_round_16_2: one combinational SHA-256 round over the packed {a..h} working state.
module sha256_round_16_2
    import sha256_pkg::*;
(
    input  logic [255:0] st_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] st_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] s0, s1, ch, maj, t1, t2;

    always_comb begin
        {a, b, c, d, e, f, g, h} = st_in;
        s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
        ch = (e & f) ^ (~e & g);
        t1 = h + s1 + ch + k + w;
        s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
        maj = (a & b) ^ (a & c) ^ (b & c);
        t2 = s0 + maj;
        st_out = {t1 + t2, a, b, c, d + t1, e, f, g};
    end

endmodule

// File: rtl/sha256_compress_iter_16_2.sv
// sha256_compress_iter_16_2: iterative one-round-per-beat SHA-256 compression of one block.
// SHA256_DIGEST_BYTESWAP_EN: emit the digest fully byte-reversed (Bitcoin internal order).
module sha256_compress_iter_16_2
    import sha256_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [255:0] h_in,
    input  logic [31:0]  w_in,
    input  logic         w_valid,
    output logic         w_ready,
    output logic         busy,
    output logic [5:0]   round_cnt,
    output logic [255:0] digest_out,
    output logic         digest_valid,
    input  logic         digest_ready
);

    state_t state, state_nxt;
    logic [255:0] st, hold, st_rnd, sum, res;
    logic adv;

    sha256_round_16_2 u_round (
        .st_in (st),
        .k     (K[round_cnt]),
        .w     (w_in),
        .st_out(st_rnd)
    );

    assign adv = (state == ROUND) && w_valid;
    assign w_ready = state == ROUND;
    assign busy = state != IDLE;
    assign digest_valid = state == DONE;

    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) sum[32*i +: 32] = hold[32*i +: 32] + st[32*i +: 32];
    end

`ifdef SHA256_DIGEST_BYTESWAP_EN
    assign res = {<<8{sum}};
`else
    assign res = sum;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = start ? ROUND : IDLE;
            ROUND: state_nxt = (w_valid && round_cnt == 6'd63) ? FINAL : ROUND;
            FINAL: state_nxt = DONE;
            DONE:  state_nxt = digest_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            st <= '0;
            hold <= '0;
            round_cnt <= '0;
            digest_out <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                st <= h_in;
                hold <= h_in;
                round_cnt <= '0;
            end
            if (adv) begin
                st <= st_rnd;
                round_cnt <= round_cnt + 6'd1;
            end
            if (state == FINAL) digest_out <= res;
        end
    end

endmodule

// File: tb/tb_sha256_compress_iter_16_2.sv
// tb_sha256_compress_iter_16_2: directed SHA-256 vectors checked against an in-bench reference model.
module tb_sha256_compress_iter_16_2;
    import sha256_pkg::K;

    localparam logic [255:0] IVB = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DBL = 256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456;
    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMP = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_DBL = {EMP, 32'h80000000, 192'h0, 32'h00000100};

    logic CLK = 1'b0;
    logic RST, start, w_valid, digest_ready;
    logic [255:0] h_in;
    logic [31:0] w_in;
    logic w_ready, busy, digest_valid;
    logic [5:0] round_cnt;
    logic [255:0] digest_out;

    int ncmp = 0, nbad = 0, cyc = 0;
    bit armed = 1'b0;
    logic [31:0] wstim [64];

    int ph = 0, mt = 0;
    logic [255:0] mhold = '0, mdig = '0;
    logic [31:0] wa [64];

    sha256_compress_iter_16_2 dut (
        .CLK(CLK), .RST(RST), .start(start), .h_in(h_in), .w_in(w_in),
        .w_valid(w_valid), .w_ready(w_ready), .busy(busy), .round_cnt(round_cnt),
        .digest_out(digest_out), .digest_valid(digest_valid), .digest_ready(digest_ready)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] fix(input logic [255:0] x);
        logic [255:0] r;
        r = x;
`ifdef SHA256_DIGEST_BYTESWAP_EN
        for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
`endif
        return r;
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hv, input logic [31:0] w [64]);
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = hv[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[255-32*i -: 32] + v[i];
        return r;
    endfunction

    task automatic load_block(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) wstim[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            wstim[t] = (rr(wstim[t-2], 17) ^ rr(wstim[t-2], 19) ^ (wstim[t-2] >> 10)) + wstim[t-7]
                     + (rr(wstim[t-15], 7) ^ rr(wstim[t-15], 18) ^ (wstim[t-15] >> 3)) + wstim[t-16];
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: phase 0 idle, 1 collecting 64 words, 2 finalising, 3 presenting the digest.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ph <= 0;
            mt <= 0;
            mhold <= '0;
            mdig <= '0;
        end else if (ph == 0) begin
            if (start) begin
                mhold <= h_in;
                mt <= 0;
                ph <= 1;
            end
        end else if (ph == 1) begin
            if (w_valid) begin
                wa[mt] <= w_in;
                mt <= (mt == 63) ? 0 : mt + 1;
                if (mt == 63) ph <= 2;
            end
        end else if (ph == 2) begin
            mdig <= fix(compress(mhold, wa));
            ph <= 3;
        end else if (digest_ready) ph <= 0;
    end

    always @(negedge CLK) begin
        if (armed) begin
            chk("busy", 256'(busy), 256'(ph != 0));
            chk("w_ready", 256'(w_ready), 256'(ph == 1));
            chk("digest_valid", 256'(digest_valid), 256'(ph == 3));
            chk("round_cnt", 256'(round_cnt), 256'(mt));
            chk("digest_out", digest_out, mdig);
        end
    end

    task automatic run(input logic [255:0] hin, input logic [511:0] blk, input logic [255:0] exp_be,
                       input bit stalls, input bit hold_done);
        int acc, n;
        logic [255:0] snap;
        load_block(blk);
        @(posedge CLK); #1;
        start = 1'b1;
        h_in = hin;
        @(posedge CLK); #1;
        start = 1'b0;
        acc = cyc;
        h_in = ~hin;
        for (int i = 0; i < 64; i++) begin
            if (stalls && (i == 17 || i == 63)) begin
                w_valid = 1'b0;
                w_in = $urandom;
                repeat (3) begin
                    @(posedge CLK); #1;
                    chk("stall_round_cnt", 256'(round_cnt), 256'(i));
                end
            end
            w_in = wstim[i];
            w_valid = 1'b1;
            @(posedge CLK); #1;
        end
        w_valid = 1'b0;
        w_in = $urandom;
        n = 0;
        while (!digest_valid && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("latency", 256'(cyc - acc), stalls ? 256'd71 : 256'd65);
        chk("digest_literal", digest_out, fix(exp_be));
        chk("model_literal", mdig, fix(exp_be));
        if (hold_done) begin
            snap = digest_out;
            repeat (10) begin
                @(posedge CLK); #1;
                chk("hold_valid", 256'(digest_valid), 256'd1);
                chk("hold_digest", digest_out, snap);
            end
            start = 1'b1;
            @(posedge CLK); #1;
            start = 1'b0;
            chk("start_in_done_busy", 256'(busy), 256'd1);
            chk("start_in_done_valid", 256'(digest_valid), 256'd1);
        end
        digest_ready = 1'b1;
        start = 1'b1;
        @(posedge CLK); #1;
        digest_ready = 1'b0;
        start = 1'b0;
        chk("idle_after_accept", 256'(busy), 256'd0);
        @(posedge CLK); #1;
        chk("no_back_to_back", 256'(busy), 256'd0);
        chk("digest_retained", digest_out, fix(exp_be));
    endtask

    initial begin
        RST = 1'b1;
        start = 1'b0;
        h_in = '0;
        w_in = '0;
        w_valid = 1'b0;
        digest_ready = 1'b0;
        #3 RST = 1'b0;
        #1 armed = 1'b1;
        chk("reset_digest", digest_out, 256'd0);
        chk("reset_busy", 256'({busy, w_ready, digest_valid}), 256'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        w_valid = 1'b1;
        w_in = 32'hdeadbeef;
        repeat (2) @(posedge CLK);
        #1 chk("w_valid_idle", 256'({busy, round_cnt}), 256'd0);
        w_valid = 1'b0;

        run(IVB, BLK_ABC, ABC, 1'b0, 1'b1);
        run(IVB, BLK_EMP, EMP, 1'b0, 1'b0);
        run(IVB, BLK_DBL, DBL, 1'b0, 1'b0);
        run(IVB, BLK_ABC, ABC, 1'b1, 1'b0);

        load_block(BLK_ABC);
        @(posedge CLK); #1;
        start = 1'b1;
        h_in = IVB;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            w_in = wstim[i];
            w_valid = 1'b1;
            @(posedge CLK); #1;
        end
        chk("pre_reset_round_cnt", 256'(round_cnt), 256'd30);
        RST = 1'b0;
        #1;
        chk("mid_reset_outputs", 256'({busy, w_ready, digest_valid, round_cnt}), 256'd0);
        chk("mid_reset_digest", digest_out, 256'd0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        w_valid = 1'b0;
        repeat (80) begin
            @(posedge CLK); #1;
            chk("no_spurious_valid", 256'(digest_valid), 256'd0);
        end
        run(IVB, BLK_ABC, ABC, 1'b0, 1'b0);

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/sha256_compress_iter_16_2.md
SHA256_COMPRESS_ITER_16_2 -- requirements
Module: sha256_compress_iter_16_2

Interface
REQ-001 The block SHALL expose ports: CLK  in  1  rising-edge clock.
REQ-002 RST  in  1  SHALL be the asynchronous, active-low reset; assertion clears all state immediately.
REQ-003 start  in  1  SHALL be the request to begin one compression; sampled only in IDLE.
REQ-004 h_in  in  256  SHALL be the chaining value {H0..H7}, H0 in [255:224], captured on start.
REQ-005 w_in  in  32  SHALL be the schedule word W[t], taken from the W pipeline window's low word.
REQ-006 w_valid  in  1  SHALL qualify w_in.
REQ-007 w_ready  out  1  SHALL be high exactly while the state is ROUND.
REQ-008 busy  out  1  SHALL be high in every state except IDLE.
REQ-009 round_cnt  out  6  SHALL be the index t of the next round.
REQ-010 digest_out  out  256  SHALL be the result {H0'..H7'}.
REQ-011 digest_valid  out  1  SHALL be high only in DONE; digest_ready  in  1  SHALL be the consumer accept.

Function
REQ-012 The FSM SHALL have the states IDLE, ROUND, FINAL and DONE.
REQ-013 IDLE with start=1: a..h SHALL load from h_in, h_in SHALL be copied to a hold register, round_cnt SHALL be set to 0, and the next state SHALL be ROUND.
REQ-014 ROUND: each cycle with w_valid&w_ready SHALL perform one standard SHA-256 round using K[round_cnt] and w_in, then increment round_cnt.
REQ-015 ROUND with w_valid=0: all state SHALL hold (stall) and no round SHALL be consumed.
REQ-016 The beat at round_cnt=63 SHALL transition to FINAL; round_cnt SHALL wrap to 0.
REQ-017 FINAL: digest_out SHALL be set to the hold register + {a..h}, word-wise mod 2^32, and the next state SHALL be DONE.
REQ-018 DONE: digest_valid=1 and digest_out SHALL be stable until digest_ready=1, then the next state SHALL be IDLE.
REQ-019 start SHALL be ignored outside IDLE, including the DONE cycle in which digest_ready=1; no back-to-back accept is allowed.
REQ-020 w_valid SHALL be ignored outside ROUND.
REQ-021 All additions SHALL be 32-bit modulo 2^32 with carries discarded.
REQ-022 Latency: with w_valid held high, digest_valid SHALL rise after exactly 65 rising edges following the edge that accepted start.
REQ-023 digest_out SHALL retain its last value after leaving DONE until the next FINAL.

Reset
REQ-024 Reset SHALL force state=IDLE and round_cnt=0, and SHALL clear a..h, the hold register and digest_out to 0, with digest_valid=0, w_ready=0 and busy=0.
REQ-025 Reset asserted mid-compression SHALL abort the compression with no partial digest and no digest_valid pulse after release.

Configuration
REQ-026 With macro SHA256_DIGEST_BYTESWAP_EN defined, digest_out SHALL be the full 32-byte reversal of the big-endian result, i.e. the Bitcoin internal order.
REQ-027 Without SHA256_DIGEST_BYTESWAP_EN, digest_out SHALL be big-endian {H0'..H7'}; latency SHALL be identical in both builds.

Structure
REQ-028 The package sha256_pkg SHALL hold the 64-entry K constant table, the IV constants H0..H7, and the state-encoding constants.
REQ-029 The sub-module sha256_round_16_2 SHALL be combinational: it takes {a..h}, K and W and returns the next {a..h} using Sigma0, Sigma1, Ch and Maj. This block SHALL instantiate it once.

Verification
REQ-030 The bench SHALL apply h_in=IV with the "abc" W[0..63] stream (W0=61626380, W15=00000018) and continuous w_valid -> digest_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad after exactly 65 edges.
REQ-031 Double hash of "": the bench SHALL apply a second pass with h_in=IV, W0..7=e3b0c442...7852b855, W8=80000000, W15=00000100 -> digest_out=5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456, byte-reversed under SHA256_DIGEST_BYTESWAP_EN.
REQ-032 The "abc" run with w_valid deasserted for 3 cycles at t=17 and t=63 -> same digest, 6 cycles later, and round_cnt frozen during the gaps.
REQ-033 digest_ready held low for 10 cycles -> digest_valid and digest_out stable throughout; start pulsed in DONE -> ignored and busy stays high.
REQ-034 RST driven low at round_cnt=30, then released, then a fresh "abc" run -> all outputs 0 during reset and the correct digest from the fresh run with no earlier spurious digest_valid.
